output_pack_writer: RTL

Parametrised successor to the layer output writer. Collects NUM_CH byte streams from the PE array and packs PACK consecutive beats per channel into one wide word. Writes each word to the output buffer with tiled address generation: column, part, row and depth. Optional ping-pong bank switching is supported. Geometry is runtime-configured from ports rather than a hard-coded layer table; sits between the PE array output and the output-buffer BRAM write port.

---
 rtl/output_pack_writer_pkg.sv | 27 ++
 rtl/output_pack_writer_byte_packer.sv | 34 +++
 rtl/output_pack_writer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/output_pack_writer_pkg.sv
// Shared types and helpers for the packed output writer.
package output_pack_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b001,
        S_CONFIG = 3'b010,
        S_WORK   = 3'b100
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Base word address of a part inside a bank.
    function automatic logic [31:0] part_base(
        input logic        bank,
        input logic [31:0] part,
        input int unsigned nparts,
        input int unsigned pdepth
    );
        return ({31'd0, bank} * nparts + part) * pdepth;
    endfunction

endpackage

// File: rtl/output_pack_writer_byte_packer.sv
// One channel of the packer: collects beats into a wide word, lane chosen by parent.
module byte_packer #(
    parameter int DATA_WIDTH_I = 8,
    parameter int PACK         = 8,
    parameter int LANE_W       = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic                         i_en,
    input  logic [LANE_W-1:0]            i_lane,
    input  logic [DATA_WIDTH_I-1:0]      i_din,
    output logic [DATA_WIDTH_I*PACK-1:0] o_word
);

    logic [DATA_WIDTH_I*PACK-1:0] r_word;
    logic [DATA_WIDTH_I*PACK-1:0] w_word;

    // Merged view includes the beat arriving this cycle, so a completed
    // word is available to the parent without an extra stage.
    always_comb begin
        w_word = r_word;
        if (i_en) w_word[i_lane*DATA_WIDTH_I +: DATA_WIDTH_I] = i_din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       r_word <= '0;
        else if (i_clear) r_word <= '0;
        else if (i_en)    r_word <= w_word;
    end

    assign o_word = w_word;

endmodule

// File: rtl/output_pack_writer.sv
// Packs NUM_CH beat streams into wide words and writes them with tiled addressing.
module output_pack_writer
    import output_pack_writer_pkg::*;
#(
    parameter int DATA_WIDTH_I = 8,
    parameter int PACK         = 8,
    parameter int NUM_CH       = 2,
    parameter int ADDR_WIDTH   = 13,
    parameter int NUM_PARTS    = 4,
    parameter int PART_DEPTH   = 1024,
    parameter int CFG_W        = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [CFG_W-1:0]                     cfg_width,
    input  logic [CFG_W-1:0]                     cfg_height,
    input  logic [CFG_W-1:0]                     cfg_depth,
    input  logic                                 cfg_pingpong,
    input  logic                                 en_in,
    input  logic [NUM_CH*DATA_WIDTH_I-1:0]       din,
    output logic                                 busy,
    output logic                                 tile_done,
    output logic                                 job_done,
    output logic                                 ovf_err,
    output logic                                 en_wr,
    output logic [ADDR_WIDTH-1:0]                addr_wr,
    output logic [NUM_CH*DATA_WIDTH_I*PACK-1:0]  dout
);

    localparam int DWO    = DATA_WIDTH_I * PACK;
    localparam int LANE_W = (clog2(PACK) < 1) ? 1 : clog2(PACK);
    localparam int PART_W = (clog2(NUM_PARTS) < 1) ? 1 : clog2(NUM_PARTS);
    localparam int OFF_W  = (clog2(PART_DEPTH) < 1) ? 1 : clog2(PART_DEPTH);
    localparam int ROW_W  = 2 * CFG_W;

    state_t r_state, w_next;

    logic [LANE_W-1:0]       r_lane;
    logic [CFG_W-1:0]        r_width, r_height, r_depth;
    logic [CFG_W-1:0]        r_col, r_row, r_tile;
    logic [PART_W-1:0]       r_part;
    logic [ROW_W-1:0]        r_row_off;
    logic                    r_bank, r_pp;
    logic                    r_en_wr, r_tile_done, r_job_done, r_ovf;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [NUM_CH*DWO-1:0]   r_dout;

    logic                    w_cfg, w_beat, w_word;
    logic                    w_last_col, w_last_part, w_last_row, w_last_tile;
    logic                    w_tile_end, w_job_end, w_ovf;
    logic [ROW_W-1:0]        w_sum;
    logic [ROW_W:0]          w_end;
    logic [31:0]             w_base;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [NUM_CH*DWO-1:0]   w_packed;

    assign w_cfg  = (r_state == S_CONFIG);
    assign w_beat = en_in && (r_state == S_WORK);
    assign w_word = w_beat && (r_lane == LANE_W'(PACK - 1));

    assign w_last_col  = (r_col  == r_width  - CFG_W'(1));
    assign w_last_part = (r_part == PART_W'(NUM_PARTS - 1));
    assign w_last_row  = (r_row  == r_height - CFG_W'(1));
    assign w_last_tile = (r_tile == r_depth  - CFG_W'(1));
    assign w_tile_end  = w_word && w_last_col && w_last_part && w_last_row;
    assign w_job_end   = w_tile_end && w_last_tile;

    // Row offset wraps inside the part; overflow is only flagged.
    assign w_sum  = r_row_off + {{CFG_W{1'b0}}, r_col};
    assign w_end  = {1'b0, r_row_off} + {{(CFG_W + 1){1'b0}}, r_width};
    assign w_ovf  = (w_end > (ROW_W + 1)'(PART_DEPTH));
    assign w_base = part_base(r_bank, 32'(r_part), NUM_PARTS, PART_DEPTH);
    assign w_addr = w_base[ADDR_WIDTH-1:0]
                  + {{(ADDR_WIDTH - OFF_W){1'b0}}, w_sum[OFF_W-1:0]};

    genvar ch;
    generate
        for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
            byte_packer #(
                .DATA_WIDTH_I (DATA_WIDTH_I),
                .PACK         (PACK),
                .LANE_W       (LANE_W)
            ) u_packer (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_clear (w_cfg),
                .i_en    (w_beat),
                .i_lane  (r_lane),
                .i_din   (din[ch*DATA_WIDTH_I +: DATA_WIDTH_I]),
                .o_word  (w_packed[ch*DWO +: DWO])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_CONFIG;
            S_CONFIG: w_next = S_WORK;
            S_WORK:   if (w_job_end) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane      <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_depth     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_tile      <= '0;
            r_part      <= '0;
            r_row_off   <= '0;
            r_bank      <= 1'b0;
            r_pp        <= 1'b0;
            r_en_wr     <= 1'b0;
            r_tile_done <= 1'b0;
            r_job_done  <= 1'b0;
            r_ovf       <= 1'b0;
            r_addr      <= '0;
            r_dout      <= '0;
        end else begin
            r_en_wr     <= w_word;
            r_tile_done <= w_tile_end;
            r_job_done  <= w_job_end;
            if (w_word) begin
                r_dout <= w_packed;
                r_addr <= w_addr;
            end
            if (w_cfg) begin
                r_width   <= (cfg_width  == '0) ? CFG_W'(1) : cfg_width;
                r_height  <= (cfg_height == '0) ? CFG_W'(1) : cfg_height;
                r_depth   <= (cfg_depth  == '0) ? CFG_W'(1) : cfg_depth;
                r_pp      <= cfg_pingpong;
                r_lane    <= '0;
                r_col     <= '0;
                r_row     <= '0;
                r_tile    <= '0;
                r_part    <= '0;
                r_row_off <= '0;
                r_bank    <= 1'b0;
                r_ovf     <= 1'b0;
            end else if (w_beat) begin
                r_lane <= w_word ? '0 : r_lane + LANE_W'(1);
                if (w_word) begin
                    if (w_ovf) r_ovf <= 1'b1;
                    if (!w_last_col) begin
                        r_col <= r_col + CFG_W'(1);
                    end else begin
                        r_col <= '0;
                        if (!w_last_part) begin
                            r_part <= r_part + PART_W'(1);
                        end else begin
                            r_part <= '0;
                            if (!w_last_row) begin
                                r_row     <= r_row + CFG_W'(1);
                                r_row_off <= r_row_off + {{CFG_W{1'b0}}, r_width};
                            end else begin
                                r_row     <= '0;
                                r_row_off <= '0;
                                r_tile    <= r_tile + CFG_W'(1);
                                if (r_pp) r_bank <= ~r_bank;
                            end
                        end
                    end
                end
            end
        end
    end

    assign busy      = (r_state == S_CONFIG) || (r_state == S_WORK);
    assign tile_done = r_tile_done;
    assign job_done  = r_job_done;
    assign ovf_err   = r_ovf;
    assign en_wr     = r_en_wr;
    assign addr_wr   = r_addr;
    assign dout      = r_dout;

endmodule
